// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, FSM state type and widths for the keypad entry block
package keypad_pkg;

    localparam int BCD_W = 4;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - synchronise and debounce the decoded key, emit one pulse per press
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   key_valid   decoder valid, asynchronous to clk
//   key_number  decoder key code, meaningful only with key_valid
//   press       one-cycle pulse when the debounced key goes from no-key to key
//   press_code  debounced key code, valid while press is high
module keypad_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_number,
    output logic       press,
    output logic [3:0] press_code
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYCLES - 2);

    // {valid, code}; the code is zeroed when no key is down so "no key" has one encoding
    logic [4:0]       sample_in;
    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic [4:0]       cand;
    logic [4:0]       deb;
    logic             deb_prev_valid;
    logic [CNT_W-1:0] cnt;

    assign sample_in = {key_valid, key_valid ? key_number : 4'd0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1          <= '0;
            sync2          <= '0;
            cand           <= '0;
            deb            <= '0;
            deb_prev_valid <= 1'b0;
            cnt            <= '0;
        end else begin
            sync1          <= sample_in;
            sync2          <= sync1;
            deb_prev_valid <= deb[4];
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
                // Load on the same edge the counter lands on its terminal value
                if (cnt >= CNT_PRE) begin
                    deb <= cand;
                end
            end
        end
    end

    assign press      = deb[4] & ~deb_prev_valid;
    assign press_code = deb[3:0];

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - collect debounced key presses into a BCD entry and hand it off
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key_valid    decoder valid, asynchronous to clk
//   key_number   decoder key code (0-9 digit, 10 CLEAR, 11 ENTER, 12-15 ignored)
//   entry_valid  completed entry is available
//   entry_ready  consumer accepts the entry
//   entry_value  BCD digits, most recent digit in [3:0]
//   entry_count  number of digits currently held
//   busy         digits held or an entry is being presented
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIGITS          = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         key_valid,
    input  logic [3:0]                   key_number,
    output logic                         entry_valid,
    input  logic                         entry_ready,
    output logic [BCD_W*DIGITS-1:0]      entry_value,
    output logic [$clog2(DIGITS+1)-1:0]  entry_count,
    output logic                         busy
);

    localparam int VW = BCD_W * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic         press;
    logic [3:0]   press_code;

    entry_state_t state;
    entry_state_t state_next;
    logic [VW-1:0] value;
    logic [VW-1:0] value_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    keypad_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_number (key_number),
        .press      (press),
        .press_code (press_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            value <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            value <= value_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        value_next = value;
        count_next = count;
        case (state)
            COLLECT: begin
                if (press) begin
                    if (is_digit(press_code)) begin
                        // A full buffer silently drops further digits
                        if (count < CW'(DIGITS)) begin
                            value_next = {value[VW-BCD_W-1:0], press_code};
                            count_next = count + CW'(1);
                        end
                    end else if (press_code == KEY_CLEAR) begin
                        value_next = '0;
                        count_next = '0;
                    end else if (press_code == KEY_ENTER && count != '0) begin
                        state_next = PRESENT;
                    end
                end
            end
            PRESENT: begin
                // Keys are discarded here; only the handshake leaves this state
                if (entry_ready) begin
                    state_next = COLLECT;
                    value_next = '0;
                    count_next = '0;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    assign entry_valid = (state == PRESENT);
    assign entry_value = value;
    assign entry_count = count;
    assign busy        = (count != '0) || (state == PRESENT);

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - scoreboard bench for keypad_entry
module tb_keypad_entry;

    localparam int D = 4;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_number = 4'd0;
    logic        entry_ready = 1'b0;
    logic        entry_valid;
    logic [15:0] entry_value;
    logic [2:0]  entry_count;
    logic        busy;

    keypad_entry #(
        .DEBOUNCE_CYCLES(D),
        .DIGITS(N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_number  (key_number),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .entry_value (entry_value),
        .entry_count (entry_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        int          count;
    } entry_t;

    int     vectors = 0;
    int     miscompares = 0;
    entry_t exp_q[$];
    int     model_digits[$];
    bit     model_present = 0;
    bit     hold_ready = 0;
    int     hs_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference model: an entry is an ordered list of up to N digits.
    task automatic model_key(input int code);
        entry_t e;
        if (model_present) return;
        if (code <= 9) begin
            if (model_digits.size() < N) model_digits.push_back(code);
        end else if (code == 10) begin
            model_digits.delete();
        end else if (code == 11 && model_digits.size() > 0) begin
            e.value = 16'd0;
            foreach (model_digits[i]) e.value = e.value * 16 + 16'(model_digits[i]);
            e.count = model_digits.size();
            exp_q.push_back(e);
            model_digits.delete();
            model_present = 1;
        end
    endtask

    task automatic press(input int code, input int hold, input int rel);
        @(negedge clk);
        key_valid  = 1'b1;
        key_number = code[3:0];
        repeat (hold) @(negedge clk);
        key_valid  = 1'b0;
        key_number = 4'($urandom);
        repeat (rel) @(negedge clk);
    endtask

    task automatic key(input int code);
        model_key(code);
        press(code, $urandom_range(D, 10), $urandom_range(D, 10));
    endtask

    task automatic wait_handshake(input int start, input string name);
        int t = 0;
        while (hs_count == start && t < 300) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        if (hs_count == start) fail_now(name);
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!entry_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!entry_valid) fail_now(name);
    endtask

    // Consumer + monitor: pops an expected entry whenever one is presented
    initial begin
        bit     seen = 0;
        bit     last_v = 0;
        bit     last_r = 0;
        entry_t cur;
        cur.value = 16'd0;
        cur.count = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0; last_v = 0; last_r = 0; entry_ready = 1'b0;
                continue;
            end
            if (last_v && last_r) begin
                hs_count++;
                model_present = 0;
                check("post_hs_valid", 32'(entry_valid), 32'd0);
                check("post_hs_value", 32'(entry_value), 32'd0);
                check("post_hs_count", 32'(entry_count), 32'd0);
            end
            if (entry_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_entry: got %0h expected none", entry_value);
                        cur.value = entry_value;
                        cur.count = int'(entry_count);
                    end else begin
                        cur = exp_q.pop_front();
                        check("entry_value", 32'(entry_value), 32'(cur.value));
                        check("entry_count", 32'(entry_count), 32'(cur.count));
                    end
                    seen = 1;
                end else begin
                    check("entry_stable", 32'(entry_value), 32'(cur.value));
                end
            end else begin
                seen = 0;
            end
            entry_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) == 0);
            last_v = entry_valid;
            last_r = entry_ready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int start;
        int n;
        int code;
        int r;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(entry_valid), 32'd0);
        check("rst_value", 32'(entry_value), 32'd0);
        check("rst_count", 32'(entry_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single digit and ENTER latency
        key(5);
        check("busy_digit", 32'(busy), 32'd1);
        check("count_after_5", 32'(entry_count), 32'd1);
        start = hs_count;
        model_key(11);
        key_valid = 1'b1;
        key_number = 4'd11;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (entry_valid) break;
        end
        check("enter_latency", 32'(n), 32'd7);
        repeat (4) @(negedge clk);
        key_valid = 1'b0;
        repeat (8) @(negedge clk);
        wait_handshake(start, "hs_single");

        // Overflow digit is dropped
        start = hs_count;
        key(1); key(2); key(3); key(4); key(9); key(11);
        wait_handshake(start, "hs_overflow");

        // Glitch rejection
        for (int l = 1; l < D; l++) begin
            @(negedge clk);
            key_valid = 1'b1;
            key_number = 4'd7;
            repeat (l) @(negedge clk);
            key_valid = 1'b0;
            repeat (10) @(negedge clk);
        end
        check("glitch_count", 32'(entry_count), 32'd0);
        model_key(7);
        press(7, D, 10);
        check("min_pulse_count", 32'(entry_count), 32'd1);
        start = hs_count;
        key(11);
        wait_handshake(start, "hs_glitch");

        // CLEAR then ENTER on empty buffer
        key(8); key(6); key(10); key(11);
        repeat (10) @(negedge clk);
        check("clear_valid", 32'(entry_valid), 32'd0);
        check("clear_count", 32'(entry_count), 32'd0);

        // Keys ignored while presenting
        hold_ready = 1;
        start = hs_count;
        key(4); key(2); key(11);
        wait_valid("present_42");
        key(3); key(10);
        repeat (5) @(negedge clk);
        check("present_value", 32'(entry_value), 32'h42);
        check("present_count", 32'(entry_count), 32'd2);
        check("present_valid", 32'(entry_valid), 32'd1);
        hold_ready = 0;
        wait_handshake(start, "hs_present");

        // Key held across the handshake produces no new event
        hold_ready = 1;
        start = hs_count;
        key(1); key(11);
        wait_valid("present_held");
        @(negedge clk);
        key_valid = 1'b1;
        key_number = 4'd2;
        repeat (12) @(negedge clk);
        hold_ready = 0;
        wait_handshake(start, "hs_held");
        repeat (10) @(negedge clk);
        check("held_no_event", 32'(entry_count), 32'd0);
        key_valid = 1'b0;
        repeat (10) @(negedge clk);
        start = hs_count;
        key(2); key(11);
        wait_handshake(start, "hs_repress");

        // Asynchronous reset mid-debounce
        key(3);
        check("pre_reset_count", 32'(entry_count), 32'd1);
        @(negedge clk);
        key_valid = 1'b1;
        key_number = 4'd5;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_deb_count", 32'(entry_count), 32'd0);
        check("arst_deb_value", 32'(entry_value), 32'd0);
        check("arst_deb_busy", 32'(busy), 32'd0);
        model_digits.delete();
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Asynchronous reset while presenting
        hold_ready = 1;
        key(6); key(11);
        wait_valid("present_rst");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_pr_valid", 32'(entry_valid), 32'd0);
        check("arst_pr_value", 32'(entry_value), 32'd0);
        check("arst_pr_count", 32'(entry_count), 32'd0);
        check("arst_pr_busy", 32'(busy), 32'd0);
        model_present = 0;
        model_digits.delete();
        hold_ready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Randomised key sequences
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      code = $urandom_range(0, 9);
            else if (r < 75) code = 10;
            else if (r < 93) code = 11;
            else             code = $urandom_range(12, 15);
            start = hs_count;
            n = exp_q.size();
            key(code);
            if (model_present) wait_handshake(start, "hs_random");
        end
        key(11);
        if (model_present) begin
            start = hs_count;
            wait_handshake(start, "hs_final");
        end

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
